diferential_cfg_loader: RTL
===========================

// Module: diferential_cfg_loader
// PURPOSE
//  Configuration writer for the muxpga cell array. Receives a framed nibble
//  stream on the cfg pins and assembles one 4-bit config word per cell.
//  Checks the frame, then commits the whole array config in one cycle to the
//  fabric's per-cell cfg inputs. A bad or stalled frame never disturbs the
//  active config.
// PARAMETERS
//  ROWS     3      fabric rows
//  COLS     3      fabric columns; NCELLS = ROWS*COLS
//  SYNC     4'hA   frame start nibble
//  TIMEOUT  15     max idle cycles between strobes inside a frame (>=1)
// PORTS
//  clk         in   1           fabric clock
//  reset       in   1           asynchronous, active-low reset
//  cfg_nib     in   4           stream nibble, sampled when cfg_stb=1
//  cfg_stb     in   1           nibble valid, one-cycle qualifier, synchronous to clk
//  cfg_bus     out  4*NCELLS    active config; cell k = row*COLS+col at [4k+3:4k]
//  cfg_commit  out  1           1-cycle pulse when cfg_bus updates
//  cfg_loaded  out  1           high after the first good commit since reset
//  busy        out  1           high while a frame is in progress (state != IDLE)
//  err         out  1           sticky frame error; cleared by next accepted SYNC
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; shadow, cfg_bus=0; cfg_commit, cfg_loaded,
//   busy, err=0; count, idle timer, checksum=0.
//  Frame on cfg_stb beats: SYNC, then NCELLS payload nibbles (cell 0 first),
//   then CHK = XOR of all payload nibbles.
//  FSM:
//   IDLE: stb with nib==SYNC -> LOAD; err<=0, count<=0, chk<=0, timer<=0.
//    Stb with any other nibble is ignored; no err.
//   LOAD: stb -> shadow[count]<=nib, chk^=nib, count++.
//    Beat with count==NCELLS-1 -> SUM. SYNC inside payload is ordinary data.
//   SUM: stb -> if nib==chk: cfg_bus<=shadow on the next edge, cfg_commit=1 for
//    that one cycle, cfg_loaded<=1. Else err<=1 and cfg_bus is unchanged.
//    Either result -> IDLE.
//  Latency: CHK strobe at edge N -> cfg_bus/cfg_commit valid after edge N+1.
//   cfg_commit is registered.
//  Timeout: in LOAD/SUM, timer counts cycles with stb=0 and is reset to 0 by stb.
//   When timer reaches TIMEOUT -> err<=1, state IDLE, shadow discarded.
//  Back-to-back: a SYNC strobe on the cycle right after the CHK strobe is
//   accepted. No dead cycle.
//  Shadow is separate from cfg_bus. cfg_bus changes only on a good commit and
//   on reset.
//  Reset asserted mid-frame: immediate return to reset values, including
//   cfg_bus=0. The fabric reloads from scratch.
//  Widths: count is clog2(NCELLS+1) bits. Timer is clog2(TIMEOUT+1) bits and
//   saturates (no wrap).
//  busy=1 in LOAD and SUM. err stays set through IDLE until a SYNC is accepted.
// TESTING
//  1. Stream A,1..9,CHK=1 -> cfg_bus=36'h987654321; one commit pulse one cycle
//     after CHK; cfg_loaded=1.
//  2. Same frame with CHK=2 -> err=1, cfg_bus keeps its prior value, no commit,
//     busy=0.
//  3. A,1,2 then 15 idle cycles -> err=1 on the 15th idle cycle, state IDLE.
//     A following good frame commits and clears err.
//  4. Nibbles 3,5 then A,(payload all A),CHK=A -> pre-SYNC nibbles ignored;
//     cfg_bus=36'hAAAAAAAAA.
//  5. reset=0 asynchronously during payload beat 4 -> all outputs 0 at once.
//     After release, a full good frame loads.
//  6. Two good frames back-to-back, no gap -> two commit pulses; cfg_bus ends
//     at the second payload.

Source files
------------

// File: rtl/diferential_cfg_loader.sv
// diferential_cfg_loader: frames a nibble stream into per-cell config words and commits the whole array atomically
module diferential_cfg_loader #(
    parameter int          ROWS    = 3,
    parameter int          COLS    = 3,
    parameter logic [3:0]  SYNC    = 4'hA,
    parameter int          TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                cfg_nib,
    input  logic                      cfg_stb,
    output logic [4*ROWS*COLS-1:0]    cfg_bus,
    output logic                      cfg_commit,
    output logic                      cfg_loaded,
    output logic                      busy,
    output logic                      err
);
    localparam int NCELLS = ROWS * COLS;
    localparam int CW     = $clog2(NCELLS + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SUM} state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q;
    logic [TW-1:0]       timer_q;
    logic [3:0]          chk_q;
    logic [4*NCELLS-1:0] shadow_q;
    logic                go_q;
    logic [3:0]          chk_d;
    logic [TW-1:0]       timer_d;
    logic                timeout;

    // running checksum, saturating idle timer and the stall condition
    always_comb begin
        chk_d   = chk_q ^ cfg_nib;
        timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + 1'b1;
        timeout = !cfg_stb && (timer_q == TW'(TIMEOUT - 1));
    end

    // frame FSM: collects payload into the shadow and flags a good checksum via go_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            timer_q  <= '0;
            chk_q    <= '0;
            shadow_q <= '0;
            go_q     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (state_q == IDLE) begin
                if (cfg_stb && cfg_nib == SYNC) begin
                    state_q <= LOAD;
                    busy    <= 1'b1;
                    err     <= 1'b0;
                    count_q <= '0;
                    chk_q   <= '0;
                    timer_q <= '0;
                end
            end else if (timeout) begin
                state_q <= IDLE;
                busy    <= 1'b0;
                err     <= 1'b1;
            end else if (!cfg_stb) begin
                timer_q <= timer_d;
            end else begin
                timer_q <= '0;
                if (state_q == LOAD) begin
                    shadow_q[4*count_q +: 4] <= cfg_nib;
                    chk_q                    <= chk_d;
                    count_q                  <= count_q + 1'b1;
                    if (count_q == CW'(NCELLS - 1))
                        state_q <= SUM;
                end else begin
                    go_q    <= (cfg_nib == chk_q);
                    err     <= (cfg_nib != chk_q);
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            end
        end
    end

    // commit stage: one edge after a good checksum the shadow becomes the active config
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_bus    <= '0;
            cfg_commit <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            cfg_commit <= go_q;
            if (go_q) begin
                cfg_bus    <= shadow_q;
                cfg_loaded <= 1'b1;
            end
        end
    end
endmodule
